fsk_bit_decoder: RTL and testbench

Downstream consumer of the two-tone frequency analyzer. Once per bit period it snapshots the analyzer's accumulated f1/f2 tick counts, decides mark or space, clears the analyzer and assembles UART-style frames into words. Completed words go to the capture controller through a valid/ready holding register. Framing, overrun and carrier-loss events are reported as one-cycle pulses.

---
 rtl/fsk_pkg.sv | 29 ++
 rtl/bit_window_timer.sv | 40 ++++
 rtl/fsk_bit_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_fsk_bit_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fsk_pkg
//  Description : Shared definitions for the FSK bit decoder: FSM state
//                encoding, bit-period derivation and mark/space constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsk_pkg;

    // Frame assembly states of the bit decoder
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } fsk_state_t;

    // Line bit values: the low tone (f1) is space, the high tone (f2) is mark
    localparam logic BIT_SPACE = 1'b0;
    localparam logic BIT_MARK  = 1'b1;

    // Clock cycles per bit period (integer division)
    function automatic int unsigned bit_ticks(input int unsigned clock_hz,
                                              input int unsigned bit_rate);
        return clock_hz / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_window_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_window_timer
//  Description : Free-running bit-window counter 0..BIT_TICKS-1 with a
//                terminal-count strobe. Held at 0 while disabled; restart
//                forces the count back to 0 for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_window_timer
    import fsk_pkg::*;
#(
    parameter int unsigned BIT_TICKS = 5000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic restart,
    output logic terminal
);

    localparam int unsigned     CNT_W      = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIT_TICKS - 1);

    logic [CNT_W-1:0] count;

    // Window counter: wraps at the terminal count, parked at 0 when idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable || restart || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = enable && !restart && (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/fsk_bit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_bit_decoder
//  Description : Samples the two-tone analyzer once per bit window, decides
//                mark/space, assembles UART-style frames into words and
//                hands them off through a valid/ready holding register.
//                Optional feature macro: FSK_DECODER_PARITY_EN (even parity
//                bit between the data bits and the stop bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module fsk_bit_decoder
    import fsk_pkg::*;
#(
    parameter int unsigned CLOCK            = 50000000,
    parameter int unsigned BIT_RATE         = 10000,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned MIN_ACTIVE_TICKS = bit_ticks(CLOCK, BIT_RATE) / 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [31:0]          f1_value,
    input  logic [31:0]          f2_value,
    output logic                 analyzer_enable,
    output logic                 analyzer_clear,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 carrier_lost,
    output logic                 parity_error
);

    localparam int unsigned      BIT_TICKS = bit_ticks(CLOCK, BIT_RATE);
    localparam int unsigned      IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 terminal;
    logic                 enable_rise;
    logic                 decide;
    logic [31:0]          snap_f1;
    logic [31:0]          snap_f2;
    logic [32:0]          sum;
    logic                 carrier_present;
    logic                 bit_value;

    fsk_state_t           state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 deliver;
    logic                 framing_next;
    logic                 carrier_next;
`ifdef FSK_DECODER_PARITY_EN
    logic                 parity_next;
`endif

    // analyzer_enable doubles as the delayed enable for edge detection
    assign enable_rise = enable && !analyzer_enable;

    // The restart on the enable edge lines the first window up with the
    // analyzer clear that accompanies it
    bit_window_timer #(
        .BIT_TICKS (BIT_TICKS)
    ) u_window_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .restart  (enable_rise),
        .terminal (terminal)
    );

    // Snapshot the analyzer at the window edge and clear it the cycle after
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            analyzer_enable <= 1'b0;
            analyzer_clear  <= 1'b0;
            decide          <= 1'b0;
            snap_f1         <= '0;
            snap_f2         <= '0;
        end else begin
            analyzer_enable <= enable;
            analyzer_clear  <= terminal || enable_rise;
            decide          <= terminal;
            if (terminal) begin
                snap_f1 <= f1_value;
                snap_f2 <= f2_value;
            end
        end
    end

    // Bit decision from the snapshot; a tie between the tones reads as mark
    assign sum             = {1'b0, snap_f1} + {1'b0, snap_f2};
    assign carrier_present = (sum >= 33'(MIN_ACTIVE_TICKS));
    assign bit_value       = (snap_f2 >= snap_f1) ? BIT_MARK : BIT_SPACE;

    // Frame FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_HUNT;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            shift <= shift_next;
        end
    end

    // Frame FSM next state; carrier loss overrides every in-frame decision
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        shift_next   = shift;
        deliver      = 1'b0;
        framing_next = 1'b0;
        carrier_next = 1'b0;
`ifdef FSK_DECODER_PARITY_EN
        parity_next  = 1'b0;
`endif
        if (!enable) begin
            state_next = ST_HUNT;
            idx_next   = '0;
        end else if (decide) begin
            if ((state != ST_HUNT) && !carrier_present) begin
                carrier_next = 1'b1;
                state_next   = ST_HUNT;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (carrier_present && (bit_value == BIT_SPACE)) begin
                            state_next = ST_DATA;
                            idx_next   = '0;
                        end
                    end
                    ST_DATA: begin
                        shift_next[idx] = bit_value;
                        if (idx == LAST_IDX) begin
                            idx_next = '0;
`ifdef FSK_DECODER_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end
`ifdef FSK_DECODER_PARITY_EN
                    ST_PARITY: begin
                        if (bit_value != (^shift)) begin
                            parity_next = 1'b1;
                            state_next  = ST_HUNT;
                        end else begin
                            state_next  = ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (bit_value == BIT_MARK) begin
                            deliver = 1'b1;
                        end else begin
                            framing_next = 1'b1;
                        end
                        state_next = ST_HUNT;
                    end
                    default: begin
                        state_next = ST_HUNT;
                    end
                endcase
            end
        end
    end

    // Line error pulses, one cycle wide, aligned with the FSM update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            framing_error <= 1'b0;
            carrier_lost  <= 1'b0;
        end else begin
            framing_error <= framing_next;
            carrier_lost  <= carrier_next;
        end
    end

`ifdef FSK_DECODER_PARITY_EN
    // Parity mismatch pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_error <= 1'b0;
        end else begin
            parity_error <= parity_next;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    // Holding register: a same-edge accept frees the slot for the new word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!data_valid || data_ready) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsk_bit_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fsk_bit_decoder
//  Description : Scoreboard bench for fsk_bit_decoder. A tone model stands in
//                for the analyzer; expected words and error pulses are queued
//                by the stimulus and popped by an independent monitor.
//                Honours FSK_DECODER_PARITY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsk_bit_decoder;

    // Short bit period keeps the run small: 50 cycles per bit
    localparam int unsigned TB_CLOCK   = 50_000_000;
    localparam int unsigned TB_RATE    = 1_000_000;
    localparam int          BT         = TB_CLOCK / TB_RATE;
    localparam int unsigned TONE_TICKS = 45;   // strong tone, well above BT/2
    localparam int unsigned WEAK_TICKS = 10;   // below BT/2: carrier absent
    localparam int          T_NONE     = 0;
    localparam int          T_SPACE    = 1;
    localparam int          T_MARK     = 2;
    // event vector layout {carrier_lost, parity_error, framing_error, overrun}
    localparam logic [3:0]  EV_OVERRUN = 4'b0001;
    localparam logic [3:0]  EV_FRAMING = 4'b0010;
    localparam logic [3:0]  EV_PARITY  = 4'b0100;
    localparam logic [3:0]  EV_CARRIER = 4'b1000;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b0;
    logic        data_ready = 1'b0;
    logic [31:0] f1_value;
    logic [31:0] f2_value;
    logic        analyzer_enable;
    logic        analyzer_clear;
    logic [7:0]  data;
    logic        data_valid;
    logic        framing_error;
    logic        overrun;
    logic        carrier_lost;
    logic        parity_error;

    int          tone    = 0;
    int unsigned cap     = 0;
    int          checks  = 0;
    int          passes  = 0;
    int          clear_cnt      = 0;
    int          cyc            = 0;
    int          last_clear_cyc = 0;
    int          last_gap       = 0;
    int          c0             = 0;

    logic [7:0]  exp_data[$];
    logic [3:0]  exp_ev[$];

    // monitor state
    logic        prev_valid = 1'b0;
    logic        prev_clear = 1'b0;
    logic [7:0]  held       = 8'h00;
    logic [3:0]  ev;
    logic [7:0]  w_exp;
    logic [3:0]  e_exp;

    fsk_bit_decoder #(
        .CLOCK     (TB_CLOCK),
        .BIT_RATE  (TB_RATE),
        .DATA_BITS (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (enable),
        .f1_value        (f1_value),
        .f2_value        (f2_value),
        .analyzer_enable (analyzer_enable),
        .analyzer_clear  (analyzer_clear),
        .data            (data),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .framing_error   (framing_error),
        .overrun         (overrun),
        .carrier_lost    (carrier_lost),
        .parity_error    (parity_error)
    );

    always #10 clock = ~clock;

    // Analyzer model: the selected tone counts up to cap, cleared by the DUT
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f1_value <= 32'd0;
            f2_value <= 32'd0;
        end else if (analyzer_clear) begin
            f1_value <= 32'd0;
            f2_value <= 32'd0;
        end else if (analyzer_enable) begin
            if (tone == T_SPACE && f1_value < cap) f1_value <= f1_value + 32'd1;
            if (tone == T_MARK  && f2_value < cap) f2_value <= f2_value + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever a word appears or a pulse fires
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            ev = {carrier_lost, parity_error, framing_error, overrun};
            if (analyzer_clear) begin
                clear_cnt++;
                last_gap       = cyc - last_clear_cyc;
                last_clear_cyc = cyc;
            end
            if (data_valid && !prev_valid) begin
                chk("word_expected", {31'd0, exp_data.size() != 0}, 32'd1);
                if (exp_data.size() != 0) begin
                    w_exp = exp_data.pop_front();
                    chk("word_data", {24'd0, data}, {24'd0, w_exp});
                end
                chk("word_latency", {31'd0, prev_clear}, 32'd1);
                held = data;
            end
            if (data_valid && data_ready)
                chk("accept_data", {24'd0, data}, {24'd0, held});
            if (ev != 4'b0000) begin
                if (exp_ev.size() == 0) begin
                    chk("unexpected_event", {28'd0, ev}, 32'd0);
                end else begin
                    e_exp = exp_ev.pop_front();
                    chk("event", {28'd0, ev}, {28'd0, e_exp});
                end
                chk("event_timing", {31'd0, prev_clear}, 32'd1);
            end
            prev_valid = data_valid;
            prev_clear = analyzer_clear;
        end
    end

    // Wait for the next analyzer_clear (the end of the current window)
    task automatic wait_clear();
        int n = 0;
        @(negedge clock);
        while (!analyzer_clear && n < 4 * BT) begin
            @(negedge clock);
            n++;
        end
        if (!analyzer_clear) chk("clear_timeout", {31'd0, analyzer_clear}, 32'd1);
    endtask

    // One bit window with the given tone; must be called aligned to a clear
    task automatic win(input int t, input int unsigned c);
        tone = t;
        cap  = c;
        wait_clear();
        tone = T_NONE;
        cap  = 0;
    endtask

    task automatic send_bit(input logic b);
        win(b ? T_MARK : T_SPACE, TONE_TICKS);
    endtask

    task automatic frame(input logic [7:0] w, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
`ifdef FSK_DECODER_PARITY_EN
        send_bit(^w);
`endif
        send_bit(stop);
    endtask

    task automatic accept();
        @(posedge clock); #1 data_ready = 1'b1;
        @(posedge clock); #1 data_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) @(negedge clock);
        chk("reset_outputs", {25'd0, analyzer_enable, analyzer_clear, data_valid,
                              framing_error, overrun, carrier_lost, parity_error}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("no_clear_after_reset", {31'd0, analyzer_clear}, 32'd0);

        // enable: one clear pulse, then idle windows
        @(posedge clock); #1 enable = 1'b1;
        wait_clear();
        #1;
        chk("analyzer_enable", {31'd0, analyzer_enable}, 32'd1);
        c0 = clear_cnt;
        repeat (3) win(T_NONE, 0);
        #1;
        chk("clear_per_window", clear_cnt - c0, 32'd3);
        chk("window_length", last_gap, BT);

        // 0xA5, held until accepted
        exp_data.push_back(8'hA5);
        frame(8'hA5, 1'b1);
        repeat (3) @(negedge clock);
        chk("a5_held_valid", {31'd0, data_valid}, 32'd1);
        chk("a5_held_data", {24'd0, data}, 32'hA5);
        accept();
        @(negedge clock);
        chk("a5_released", {31'd0, data_valid}, 32'd0);
        wait_clear();

        // two 0x3C frames, no acceptance in between: second overruns
        exp_data.push_back(8'h3C);
        exp_ev.push_back(EV_OVERRUN);
        frame(8'h3C, 1'b1);
        frame(8'h3C, 1'b1);
        repeat (3) @(negedge clock);
        chk("overrun_keeps_data", {24'd0, data}, 32'h3C);
        chk("overrun_keeps_valid", {31'd0, data_valid}, 32'd1);
        accept();
        @(negedge clock);
        chk("3c_released", {31'd0, data_valid}, 32'd0);
        wait_clear();

        // 0x11 with a space stop bit
        exp_ev.push_back(EV_FRAMING);
        frame(8'h11, 1'b0);
        repeat (3) @(negedge clock);
        chk("framing_no_valid", {31'd0, data_valid}, 32'd0);
        wait_clear();

        // weak window at data bit 3, then a clean 0x42
        exp_ev.push_back(EV_CARRIER);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        win(T_MARK, WEAK_TICKS);
        exp_data.push_back(8'h42);
        frame(8'h42, 1'b1);
        repeat (3) @(negedge clock);
        chk("42_data", {24'd0, data}, 32'h42);
        accept();
        @(negedge clock);
        chk("42_released", {31'd0, data_valid}, 32'd0);
        wait_clear();

`ifdef FSK_DECODER_PARITY_EN
        // 0x03 with a wrong parity bit, then with the right one
        exp_ev.push_back(EV_PARITY);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h03 >> i) & 8'h01) != 8'h00);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (3) @(negedge clock);
        chk("parity_no_valid", {31'd0, data_valid}, 32'd0);
        wait_clear();
        exp_data.push_back(8'h03);
        frame(8'h03, 1'b1);
        repeat (3) @(negedge clock);
        chk("parity_ok_data", {24'd0, data}, 32'h03);
        accept();
`endif

        repeat (5) @(negedge clock);
        chk("words_left", exp_data.size(), 32'd0);
        chk("events_left", exp_ev.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
